// File: rtl/xor_arb_pkg.sv
// Shared types and constants for the xor_unit_arbiter slice.
// Optional feature macro: XOR_ARB_PARITY_EN (adds the registered rsp_parity output).
package xor_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } xor_arb_state_t;

  localparam int XOR_ARB_MAX_NREQ  = 8;
  localparam int XOR_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/xor_unit_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared XOR unit.
// Optional feature macro: XOR_ARB_PARITY_EN (adds rsp_parity).
interface xor_unit_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
`ifdef XOR_ARB_PARITY_EN
  logic                  rsp_parity;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_parity
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_parity
  );
`else
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
`endif
endinterface

// File: rtl/xor32.sv
// 32-bit bitwise XOR datapath shared by the arbiter.
module xor32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = a_i ^ b_i;
endmodule

// File: rtl/xor_unit_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            any_o
);
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the closest requester to ptr_i wins last.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (req_i[idx]) begin
        grant_idx_o = idx;
        any_o       = 1'b1;
      end
    end
    if (any_o) grant_o = NREQ'(1) << grant_idx_o;
  end
endmodule

// File: rtl/xor_unit_arbiter.sv
// Shares one XOR datapath among NREQ requesters with round-robin grant and a registered response.
// Optional feature macro: XOR_ARB_PARITY_EN (registered rsp_parity = ^rsp_data).
module xor_unit_arbiter
  import xor_arb_pkg::*;
#(
  parameter int WIDTH = XOR_DEFAULT_WIDTH,
  parameter int NREQ  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  xor_unit_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  xor_arb_state_t   state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             any_req;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] op_a, op_b, xor_res;
  logic [WIDTH-1:0] data_q;
  logic [IDW-1:0]   id_q;
`ifdef XOR_ARB_PARITY_EN
  logic             parity_q;
`endif

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] idx);
    if (int'(idx) == NREQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i       (bus.req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (any_req)
  );

  assign op_a = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign op_b = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];

  generate
    if (WIDTH == 32) begin : g_xor32
      xor32 u_xor32 (.a_i(op_a), .b_i(op_b), .y_o(xor_res));
    end else begin : g_xor_generic
      assign xor_res = op_a ^ op_b;
    end
  endgenerate

  // A slot opens either because the result register is empty or because it drains this cycle.
  assign can_accept    = (state_q == IDLE) || bus.rsp_ready;
  assign accept        = can_accept && any_req;
  assign bus.req_ready = can_accept ? grant : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE:    if (any_req) state_d = HOLD;
      HOLD:    if (bus.rsp_ready) state_d = any_req ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) rr_ptr_d = next_ptr(grant_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      data_q   <= '0;
      id_q     <= '0;
`ifdef XOR_ARB_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        data_q   <= xor_res;
        id_q     <= grant_idx;
`ifdef XOR_ARB_PARITY_EN
        parity_q <= ^xor_res;
`endif
      end
    end
  end

  assign bus.rsp_valid  = (state_q == HOLD);
  assign bus.rsp_data   = data_q;
  assign bus.rsp_id     = id_q;
`ifdef XOR_ARB_PARITY_EN
  assign bus.rsp_parity = parity_q;
`endif
endmodule
